// File: rtl/counting_pkg.sv
// counting_pkg: shared types and symbol encoding for the 2-bit symbol stream
// used by counting_gen and by the 1,2,3 pattern detector.
// Contents: state_t enum, SYM_* symbol constants, GAP_W, sym_of() decode.
package counting_pkg;

   localparam int unsigned GAP_W = 4;

   localparam logic [1:0] SYM_IDLE = 2'd0;
   localparam logic [1:0] SYM_A    = 2'd1;
   localparam logic [1:0] SYM_B    = 2'd2;
   localparam logic [1:0] SYM_C    = 2'd3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EMIT1  = 3'd1,
      EMIT2  = 3'd2,
      EMIT3  = 3'd3,
      GAPW   = 3'd4,
      DONE   = 3'd5,
      FLUSH1 = 3'd6,
      FLUSH2 = 3'd7
   } state_t;

   // Symbol driven on num while in a given state.
   function automatic logic [1:0] sym_of(state_t s);
      logic [1:0] sym;
      case (s)
         EMIT1, FLUSH1: sym = SYM_A;
         EMIT2:         sym = SYM_B;
         EMIT3, FLUSH2: sym = SYM_C;
         default:       sym = SYM_IDLE;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/counting_gen_gap_timer.sv
// gap_timer: loadable down-counter with a zero flag, times the idle gap
// between events.
// Ports: clk, reset (async, active-high), load/load_val (load count),
//        dec (decrement when nonzero), zero_c (count == 0).
module gap_timer
   import counting_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [GAP_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [GAP_W-1:0] count;

   // Load has priority; the counter parks at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - GAP_W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/counting_gen.sv
// counting_gen: on an accepted start, emits cnt complete 1,2,3 events on the
// 2-bit symbol bus num, separated by GAP idle (0) symbols, then pulses done.
// Ports: clk, reset (async, active-high), start/cnt (command, accepted when
//        ready), ready (IDLE), busy (not IDLE/DONE), num (symbol bus),
//        done (completion pulse).
// Optional: define COUNTING_GEN_ABORT_EN to add input abort and output
//        aborted; an abort flushes the detector with 1,3 before DONE.
module counting_gen
   import counting_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned GAP   = 1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] cnt,
`ifdef COUNTING_GEN_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             ready,
   output logic             busy,
   output logic [1:0]       num,
   output logic             done
);

   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             gap_load, gap_dec, gap_zero_c;

   gap_timer u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .load_val (GAP_LOAD),
      .dec      (gap_dec),
      .zero_c   (gap_zero_c)
   );

   // Next-state and remaining-count logic.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      gap_load = 1'b0;
      gap_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cnt != '0) begin
                  rem_d   = cnt;
                  state_d = EMIT1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         EMIT1: state_d = EMIT2;
         EMIT2: state_d = EMIT3;
         EMIT3: begin
            // Guarded decrement keeps remaining from wrapping.
            if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
            if (rem_d == '0) begin
               state_d = DONE;
            end else if (GAP == 0) begin
               state_d = EMIT1;
            end else begin
               gap_load = 1'b1;
               state_d  = GAPW;
            end
         end
         GAPW: begin
            if (gap_zero_c) state_d = EMIT1;
            else            gap_dec = 1'b1;
         end
         DONE:    state_d = IDLE;
         FLUSH1:  state_d = FLUSH2;
         FLUSH2:  state_d = DONE;
         default: state_d = IDLE;
      endcase
`ifdef COUNTING_GEN_ABORT_EN
      // Abort overrides any emitting state, including the last EMIT3.
      if (abort && (state_q inside {EMIT1, EMIT2, EMIT3, GAPW})) begin
         rem_d    = '0;
         gap_load = 1'b0;
         gap_dec  = 1'b0;
         state_d  = FLUSH1;
      end
`endif
   end

   // State register; outputs are registered decodes of the next state so
   // they track the state exactly with no input-to-output path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         num     <= SYM_IDLE;
         done    <= 1'b0;
         busy    <= 1'b0;
         ready   <= 1'b1;
`ifdef COUNTING_GEN_ABORT_EN
         aborted <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         num     <= sym_of(state_d);
         done    <= (state_d == DONE);
         busy    <= !(state_d inside {IDLE, DONE});
         ready   <= (state_d == IDLE);
`ifdef COUNTING_GEN_ABORT_EN
         aborted <= (state_d == DONE) && (state_q == FLUSH2);
`endif
      end
   end

endmodule

// File: doc/counting_gen.md
Name: counting_gen

Overview:
- Transmit-side companion to the team's 2-bit symbol-stream pattern detector (pattern 1,2,3 on `num`).
- On request, emits N complete "1,2,3" events on a 2-bit symbol bus, with configurable idle (0) gaps between events.
- Drives the detector's `num` input in subsystem benches and in the counting datapath.
- Each emitted event produces exactly one rising edge on the detector's `ans` output.

Parameters:
- CNT_W, 8, width of the event-count request; max events per command = 2^CNT_W-1.
- GAP, 1, idle cycles (num=0) inserted between consecutive events; legal range 0..15.

Ports:
- clk    input   1       rising-edge clock
- reset  input   1       asynchronous, active-high reset
- start  input   1       command strobe; accepted when start && ready at a clk edge
- cnt    input   CNT_W   number of events requested; sampled with an accepted start
- ready  output  1       high only in IDLE
- busy   output  1       high in any state other than IDLE and DONE
- num    output  2       symbol bus to the detector; 0 = idle
- done   output  1       one-cycle pulse marking command completion

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset (asynchronous, any time, including mid-event):
  - state=IDLE, remaining=0, gap counter=0.
  - num=0, done=0, busy=0, ready=1.
  - A partially emitted event is abandoned without a flush.
- Moore FSM; all outputs decode from registered state, so no combinational input-to-output path.
- States and transitions:
  - IDLE (num=0): start && cnt!=0 → latch remaining=cnt, go EMIT1. start && cnt==0 → DONE. No start → stay.
  - EMIT1 (num=1) → EMIT2.
  - EMIT2 (num=2) → EMIT3.
  - EMIT3 (num=3): remaining decrements at this edge. If the decremented value is 0 → DONE. Else if GAP==0 → EMIT1. Else load the gap counter with GAP-1 and go GAPW.
  - GAPW (num=0): counter==0 → EMIT1, else decrement the counter.
  - DONE (num=0, done=1): → IDLE unconditionally.
- Latency:
  - start accepted at edge T → num=1 during cycle T+1.
  - Command length = 3N + (N-1)*GAP + 1 cycles, counted through DONE.
  - The next command can be accepted at the first edge after DONE.
- start while not ready is ignored. It is not queued, and cnt is not resampled.
- cnt==0: no symbols emitted; done pulses in cycle T+1.
- remaining is CNT_W bits wide and never wraps, because it is decremented only when nonzero.
- Detector compatibility:
  - Idle 0 symbols hold the detector state.
  - A following 1 moves it S3→S1, so `ans` rises once per event for any GAP value.

Optional Feature:
- Macro: COUNTING_GEN_ABORT_EN.
- With the macro defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, valid with done).
  - abort high at an edge while in EMIT1/EMIT2/EMIT3/GAPW clears remaining and enters FLUSH1 (num=1), then FLUSH2 (num=3), then DONE with done=1 and aborted=1.
  - The 1,3 flush returns the detector to S0 from any state.
  - An event whose num=3 cycle coincides with the abort edge counts as emitted.
  - abort in IDLE or DONE is ignored.
- Without the macro: no abort or aborted ports, no FLUSH states; behaviour is exactly as above.

Decomposition:
- Shared package `counting_pkg`:
  - state enum: IDLE, EMIT1, EMIT2, EMIT3, GAPW, DONE, FLUSH1, FLUSH2.
  - symbol constants SYM_IDLE=0, SYM_A=1, SYM_B=2, SYM_C=3.
  - the package is also used by the detector.
- Sub-module: `gap_timer`, a loadable down-counter with a zero flag, for GAPW.
- Everything else stays flat in `counting_gen`.

Test Plan:
- Idle and reset: reset, no start for 20 cycles → num=0, ready=1, done=0 throughout; assert reset mid-EMIT2 → num=0 immediately (asynchronous), ready=1.
- Single event, GAP=1: start with cnt=1 at T → num=1,2,3 in T+1..T+3, done=1 at T+4, ready=1 at T+5; detector `ans` rises once.
- Burst, GAP=1: cnt=3 → num sequence 1,2,3,0,1,2,3,0,1,2,3 then done; 3 rising edges on `ans`; total 12 cycles.
- Back-to-back events, GAP=0: cnt=4 → 1,2,3 repeated 4 times with no idle symbols, done at T+13; 4 `ans` rising edges.
- Boundary commands:
  - cnt=0 → done at T+1 with no nonzero num.
  - start asserted while busy with cnt=5 → ignored; the original count completes.
  - cnt=255 (CNT_W=8) → exactly 255 events.
- Abort (COUNTING_GEN_ABORT_EN): cnt=3, abort during the second event's EMIT2 → num ...,1,2,1,3,0 with done=aborted=1; the detector ends in S0; 1 `ans` rising edge.
